ysyx_ifu: RTL and testbench
===========================

Name: ysyx_ifu

Overview:
- Instruction fetch unit for the single-issue RV32 core, directly upstream of ysyx_IDU.
- Holds the architectural fetch PC and issues one instruction read at a time over a valid/ready memory request/response channel, replacing the DPI read done in the top level.
- Presents {inst, pc} to decode with a valid/ready handshake.
- Accepts a redirect (branch/jump/ecall/mret target) from the execute/PC logic.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- ADDR_W, 32, fetch address width.
- DATA_W, 32, instruction width; only 32 supported.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  ADDR_W  fetch address; equals pc while mem_req_valid=1.
- mem_rsp_valid  in  1  read data valid.
- mem_rsp_ready  out  1  IFU accepts response.
- mem_rsp_data  in  DATA_W  instruction word.
- mem_rsp_err  in  1  bus error on this response.
- out_valid  out  1  instruction available to IDU.
- out_ready  in  1  IDU/EXU consumes instruction this cycle.
- out_inst  out  DATA_W  instruction word.
- out_pc  out  ADDR_W  PC of out_inst.
- out_fault  out  1  fetch fault: bus error or misaligned PC.
- redirect_valid  in  1  next PC is redirect_pc instead of pc+4.
- redirect_pc  in  ADDR_W  redirect target.

Behaviour:
- Reset (rst=0 at posedge):
  - state=REQ, pc=RESET_PC, drop=0.
  - out_valid=0, out_inst=0, out_fault=0, mem_rsp_ready=0.
  - mem_req_valid is low during reset.
  - Reset mid-transaction abandons any outstanding request. Any late response is ignored while in REQ, because mem_rsp_ready=0.
- States: REQ, WAIT, HOLD. At most one outstanding request.
- REQ:
  - mem_req_valid=1 and mem_req_addr=pc, unless pc[1:0]!=0.
  - On req handshake -> WAIT.
  - If pc[1:0]!=0: no request is issued. Next cycle -> HOLD with out_fault=1, out_inst=0, out_pc=pc.
- WAIT:
  - mem_rsp_ready=1.
  - On mem_rsp_valid with drop=1: clear drop, discard data -> REQ.
  - On mem_rsp_valid with drop=0: latch out_inst=mem_rsp_data, out_fault=mem_rsp_err, out_pc=pc -> HOLD.
- HOLD:
  - out_valid=1; outputs stable until consumed.
  - On out_ready: pc <= redirect_valid ? redirect_pc : pc+4 (wraps mod 2^32) -> REQ.
- Redirect handling:
  - Redirect has priority over +4 in every state.
  - HOLD without out_ready: pc<=redirect_pc, held instruction discarded, out_valid=0 next cycle -> REQ.
  - REQ without handshake: pc<=redirect_pc, stay REQ.
  - REQ with req handshake in the same cycle: pc<=redirect_pc, drop=1 -> WAIT.
  - WAIT: pc<=redirect_pc, drop=1. If the response arrives in the same cycle, discard it -> REQ.
- Latency:
  - Zero-wait memory: request in cycle 0, response in cycle 1, out_valid in cycle 2.
  - Peak throughput: one instruction per 3 cycles.
- mem_rsp_valid outside WAIT is ignored.

Optional Feature:
- Macro YSYX_IFU_PERF_EN.
- Defined: adds 64-bit outputs perf_fetch_cnt and perf_stall_cnt.
  - perf_fetch_cnt increments on each out handshake.
  - perf_stall_cnt increments each cycle in WAIT.
  - Both reset to 0 and wrap.
- Undefined: no counters and no ports; functional behaviour is identical.

Decomposition:
- Package ysyx_ifu_pkg:
  - state enum {REQ, WAIT, HOLD}.
  - INST_NOP=32'h0000_0013.
  - Default RESET_PC constant.
- One optional sub-module, ysyx_ifu_perf, holding the counters. It is instantiated only under YSYX_IFU_PERF_EN.

Test Plan:
- Reset release, zero-wait memory returning 0x00000413 at 0x80000000, out_ready=1 -> mem_req_addr=0x80000000; out_valid in cycle 2 with out_pc=0x80000000; next request addr 0x80000004.
- Memory with 3-cycle response delay, out_ready held 0 for 4 cycles -> out_valid, out_inst and out_pc stay stable; exactly one request outstanding.
- Redirect to 0x80000100 asserted during WAIT -> that response is discarded, no out_valid for it; next mem_req_addr=0x80000100.
- Redirect coinciding with out_ready in HOLD at pc 0x80000008 -> next mem_req_addr is redirect_pc, not 0x8000000C.
- Redirect to 0x80000102 -> no memory request; out_valid=1, out_fault=1, out_pc=0x80000102.
- Response with mem_rsp_err=1 -> out_fault=1 with out_pc matching the request; rst=0 during WAIT -> pc=0x80000000, out_valid=0.

Source files
------------

// File: rtl/ysyx_ifu_pkg.sv
// Shared types and constants for the ysyx_ifu instruction fetch unit.
package ysyx_ifu_pkg;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } ifu_state_e;

   localparam logic [31:0] INST_NOP         = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_ifu_perf.sv
// Fetch performance counters for ysyx_ifu: delivered instructions and cycles spent waiting on memory.
module ysyx_ifu_perf (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_fire,
   input  logic        wait_cycle,
   output logic [63:0] perf_fetch_cnt,
   output logic [63:0] perf_stall_cnt
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_fetch_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (fetch_fire) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
         if (wait_cycle) perf_stall_cnt <= perf_stall_cnt + 64'd1;
      end
   end

endmodule

// File: rtl/ysyx_ifu.sv
// Instruction fetch unit: one outstanding memory read at a time, {inst, pc} handed to decode.
// Optional fetch/stall counters and their ports are built when YSYX_IFU_PERF_EN is defined.
module ysyx_ifu
   import ysyx_ifu_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_rsp_valid,
   output logic              mem_rsp_ready,
   input  logic [DATA_W-1:0] mem_rsp_data,
   input  logic              mem_rsp_err,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_inst,
   output logic [ADDR_W-1:0] out_pc,
   output logic              out_fault,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc
`ifdef YSYX_IFU_PERF_EN
   ,
   output logic [63:0]       perf_fetch_cnt,
   output logic [63:0]       perf_stall_cnt
`endif
);

   ifu_state_e        state;
   logic [ADDR_W-1:0] pc;
   logic              drop;
   logic              misaligned;
   logic              req_fire;
   logic              rsp_fire;
   logic              out_fire;

   assign misaligned    = pc[1:0] != 2'b00;
   assign mem_req_valid = rst && (state == REQ) && !misaligned;
   assign mem_req_addr  = pc;
   // Responses are only accepted in WAIT, so a reply to a request abandoned by reset is ignored.
   assign mem_rsp_ready = state == WAIT;
   assign out_valid     = state == HOLD;
   assign out_pc        = pc;

   assign req_fire = mem_req_valid && mem_req_ready;
   assign rsp_fire = mem_rsp_ready && mem_rsp_valid;
   assign out_fire = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= REQ;
         pc        <= RESET_PC;
         drop      <= 1'b0;
         out_inst  <= '0;
         out_fault <= 1'b0;
      end else begin
         if (redirect_valid) pc <= redirect_pc;
         case (state)
            REQ: begin
               if (misaligned) begin
                  if (!redirect_valid) begin
                     state     <= HOLD;
                     out_inst  <= '0;
                     out_fault <= 1'b1;
                  end
               end else if (req_fire) begin
                  state <= WAIT;
                  drop  <= redirect_valid;
               end
            end
            WAIT: begin
               // A redirect while waiting turns the in-flight reply into one to discard.
               if (rsp_fire) begin
                  drop <= 1'b0;
                  if (drop || redirect_valid) begin
                     state <= REQ;
                  end else begin
                     state     <= HOLD;
                     out_inst  <= mem_rsp_data;
                     out_fault <= mem_rsp_err;
                  end
               end else if (redirect_valid) begin
                  drop <= 1'b1;
               end
            end
            HOLD: begin
               if (out_fire || redirect_valid) begin
                  state <= REQ;
                  if (!redirect_valid) pc <= pc + ADDR_W'(4);
               end
            end
            default: state <= REQ;
         endcase
      end
   end

`ifdef YSYX_IFU_PERF_EN
   ysyx_ifu_perf u_perf (
      .clk            (clk),
      .rst            (rst),
      .fetch_fire     (out_fire),
      .wait_cycle     (state == WAIT),
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_stall_cnt (perf_stall_cnt)
   );
`else
   // Counters not built; fetch behaviour is unchanged.
`endif

endmodule

// File: tb/tb_ysyx_ifu.sv
// Self-checking bench for ysyx_ifu: directed scenarios followed by randomized traffic against a transaction model.
module tb_ysyx_ifu;

   logic        clk;
   logic        rst;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic        mem_rsp_ready;
   logic [31:0] mem_rsp_data;
   logic        mem_rsp_err;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        out_fault;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
`ifdef YSYX_IFU_PERF_EN
   logic [63:0] perf_fetch_cnt;
   logic [63:0] perf_stall_cnt;
`endif

   ysyx_ifu dut (
      .clk            (clk),
      .rst            (rst),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_ready  (mem_rsp_ready),
      .mem_rsp_data   (mem_rsp_data),
      .mem_rsp_err    (mem_rsp_err),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc         (out_pc),
      .out_fault      (out_fault),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
`ifdef YSYX_IFU_PERF_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] memf(input logic [31:0] a);
      if (a == 32'h8000_0000) return 32'h0000_0413;
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   function automatic logic errf(input logic [31:0] a);
      return a[6:2] == 5'h17;
   endfunction

   // Memory responder state
   logic        mem_pend = 1'b0;
   logic [31:0] mem_addr = '0;
   int          mem_cnt  = 0;
   int          mem_delay = 0;
   bit          mem_rand  = 1'b0;
   bit          spurious  = 1'b0;

   // Transaction-level model of the fetch unit
   bit          model_ok = 1'b0;
   logic [31:0] m_pc     = '0;
   bit          m_busy   = 1'b0;
   bit          m_stale  = 1'b0;
   bit          m_avail  = 1'b0;
   logic [31:0] m_inst   = '0;
   bit          m_fault  = 1'b0;
   logic [63:0] m_nfetch = '0;
   logic [63:0] m_nstall = '0;
   int          m_nout_all = 0;

   always @(posedge clk) begin
      if (!rst) begin
         model_ok = 1'b1;
         m_pc = 32'h8000_0000;
         m_busy = 1'b0; m_stale = 1'b0; m_avail = 1'b0;
         m_inst = '0; m_fault = 1'b0;
         m_nfetch = '0; m_nstall = '0;
         mem_pend = 1'b0;
      end else if (model_ok) begin
         if (mem_req_valid && mem_req_ready) chk("one_outstanding", mem_pend, 0);
         if (mem_pend && mem_rsp_valid && mem_rsp_ready) mem_pend = 1'b0;
         else if (mem_pend && mem_cnt > 0) mem_cnt--;
         if (mem_req_valid && mem_req_ready) begin
            mem_pend = 1'b1;
            mem_addr = mem_req_addr;
            mem_cnt  = mem_rand ? int'($urandom % 4) : mem_delay;
         end

         if (m_busy) m_nstall++;
         if (m_avail && out_ready) begin m_nfetch++; m_nout_all++; end
         if (m_avail) begin
            if (out_ready || redirect_valid) m_avail = 1'b0;
            if (!redirect_valid && out_ready) m_pc = m_pc + 32'd4;
         end else if (m_busy) begin
            if (mem_rsp_valid) begin
               m_busy = 1'b0;
               if (!m_stale && !redirect_valid) begin
                  m_avail = 1'b1; m_inst = mem_rsp_data; m_fault = mem_rsp_err;
               end
               m_stale = 1'b0;
            end else if (redirect_valid) m_stale = 1'b1;
         end else if (m_pc[1:0] != 2'b00) begin
            if (!redirect_valid) begin m_avail = 1'b1; m_inst = '0; m_fault = 1'b1; end
         end else if (mem_req_ready) begin
            m_busy = 1'b1; m_stale = redirect_valid;
         end
         if (redirect_valid) m_pc = redirect_pc;
      end
   end

   // Compare process: DUT outputs against the model every cycle
   logic cmp_req;
   always @(negedge clk) begin
      if (!rst) chk("req_valid_in_rst", mem_req_valid, 0);
      else if (model_ok) begin
         cmp_req = !m_busy && !m_avail && (m_pc[1:0] == 2'b00);
         chk("req_valid", mem_req_valid, cmp_req);
         chk("rsp_ready", mem_rsp_ready, m_busy);
         chk("out_valid", out_valid, m_avail);
         if (cmp_req) chk("req_addr", mem_req_addr, m_pc);
         if (m_avail) begin
            chk("out_pc", out_pc, m_pc);
            chk("out_inst", out_inst, m_inst);
            chk("out_fault", out_fault, m_fault);
         end
`ifdef YSYX_IFU_PERF_EN
         chk("perf_fetch", perf_fetch_cnt, m_nfetch);
         chk("perf_stall", perf_stall_cnt, m_nstall);
`endif
      end
   end

   initial begin
      mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (mem_pend && mem_cnt == 0) begin
            mem_rsp_valid = 1'b1; mem_rsp_data = memf(mem_addr); mem_rsp_err = errf(mem_addr);
         end else begin
            mem_rsp_valid = spurious && ($urandom % 8 == 0);
            mem_rsp_data  = $urandom;
            mem_rsp_err   = 1'($urandom % 2);
         end
      end
   end

   task automatic tick();
      @(negedge clk); #1;
   endtask

   task automatic wait_out(input string nm, input int lim);
      int i = 0;
      while (!out_valid && i < lim) begin tick(); i++; end
      chk(nm, out_valid, 1);
   endtask

   bit          saw;
   logic [31:0] tgt;

   initial begin
      rst = 1'b0; mem_req_ready = 1'b1; out_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0;
      repeat (3) tick();

      // Zero-wait fetch from reset
      rst = 1'b1; out_ready = 1'b1;
      #1;
      chk("t1_req_valid", mem_req_valid, 1);
      chk("t1_req_addr", mem_req_addr, 32'h8000_0000);
      tick();
      chk("t1_cycle1_no_out", out_valid, 0);
      tick();
      chk("t1_cycle2_out", out_valid, 1);
      chk("t1_out_pc", out_pc, 32'h8000_0000);
      chk("t1_out_inst", out_inst, 32'h0000_0413);
      tick();
      chk("t1_next_addr", mem_req_addr, 32'h8000_0004);

      // Slow memory, decode stalled: outputs hold
      mem_delay = 3; out_ready = 1'b0;
      wait_out("t2_out", 20);
      for (int i = 0; i < 4; i++) begin
         chk("t2_hold_valid", out_valid, 1);
         chk("t2_hold_pc", out_pc, 32'h8000_0004);
         chk("t2_hold_inst", out_inst, memf(32'h8000_0004));
         tick();
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;

      // Redirect together with consume in HOLD
      wait_out("t4_out", 20);
      chk("t4_out_pc", out_pc, 32'h8000_0008);
      out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
      tick();
      out_ready = 1'b0; redirect_valid = 1'b0;
      chk("t4_req_valid", mem_req_valid, 1);
      chk("t4_req_addr", mem_req_addr, 32'h8000_0200);

      // Redirect during WAIT discards the in-flight reply
      tick();
      chk("t3_in_wait", mem_rsp_ready, 1);
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
      tick();
      redirect_valid = 1'b0; mem_delay = 0;
      saw = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid) saw = 1'b1;
         if (mem_req_valid) break;
         tick();
      end
      chk("t3_no_out_for_dropped", saw, 0);
      chk("t3_req_valid", mem_req_valid, 1);
      chk("t3_req_addr", mem_req_addr, 32'h8000_0100);
      wait_out("t3_refetch", 10);
      chk("t3_out_pc", out_pc, 32'h8000_0100);

      // Misaligned redirect target faults without a request
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
      tick();
      redirect_valid = 1'b0;
      saw = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid) break;
         if (mem_req_valid) saw = 1'b1;
         tick();
      end
      chk("t5_out_valid", out_valid, 1);
      chk("t5_fault", out_fault, 1);
      chk("t5_out_pc", out_pc, 32'h8000_0102);
      chk("t5_out_inst", out_inst, 0);
      chk("t5_no_request", saw, 0);

      // Bus error response, then reset during WAIT
      redirect_valid = 1'b1; redirect_pc = 32'h8000_005C;
      tick();
      redirect_valid = 1'b0;
      wait_out("t6_out", 10);
      chk("t6_fault", out_fault, 1);
      chk("t6_out_pc", out_pc, 32'h8000_005C);
      chk("t6_out_inst", out_inst, memf(32'h8000_005C));
      mem_delay = 3; out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();
      chk("t6_in_wait", mem_rsp_ready, 1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("t6_rst_out_valid", out_valid, 0);
      chk("t6_rst_req_valid", mem_req_valid, 1);
      chk("t6_rst_req_addr", mem_req_addr, 32'h8000_0000);

      // Randomized traffic
      mem_rand = 1'b1; spurious = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         tick();
         rst            = ($urandom % 400 != 0);
         mem_req_ready  = ($urandom % 4 != 0);
         out_ready      = 1'($urandom % 2);
         redirect_valid = ($urandom % 10 == 0);
         tgt = 32'h8000_0000 + ($urandom % 64) * 4;
         if ($urandom % 8 == 0) tgt[1:0] = 2'($urandom_range(1, 3));
         redirect_pc = tgt;
      end
      rst = 1'b1; redirect_valid = 1'b0;
      tick();
      chk("progress", m_nout_all > 100, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
